// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared seven-segment glyph constants and frame record
package sevenseg_pkg;

   localparam int NUM_DIGITS = 4;

   // Segment bit positions on the active-low segment bus
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Active-low 7-segment hex glyphs, bit 0 = a .. bit 6 = g
   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_B = 7'h03;
   localparam logic [6:0] GLYPH_C = 7'h46;
   localparam logic [6:0] GLYPH_D = 7'h21;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_F = 7'h0E;

   // One captured frame: nibble, decimal point and decode error per digit
   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0] nib;
      logic [NUM_DIGITS-1:0]      dp;
      logic [NUM_DIGITS-1:0]      err;
   } frame_t;

endpackage

// File: rtl/sevenseg_capture_if.sv
// rtl/sevenseg_capture_if.sv - scanned display bus in, decoded frame out
interface sevenseg_capture_if;
   logic [3:0]  anode_i;
   logic [7:0]  seg_i;
   logic [15:0] digits_o;
   logic [3:0]  dp_o;
   logic [3:0]  glyph_err_o;
   logic        frame_o;
   logic        stale_o;

   // Source of the scanned bus and consumer of frames
   modport master (
      output anode_i, seg_i,
      input  digits_o, dp_o, glyph_err_o, frame_o, stale_o
   );

   // Capture block
   modport slave (
      input  anode_i, seg_i,
      output digits_o, dp_o, glyph_err_o, frame_o, stale_o
   );
endinterface

// File: rtl/sevenseg_glyph_decode.sv
// rtl/sevenseg_glyph_decode.sv - active-low 7-segment glyph to hex nibble
module sevenseg_glyph_decode
   import sevenseg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       err
);

   // Match against the 16 hex glyphs; anything else decodes as 0 with err
   always_comb begin
      nibble = 4'h0;
      err    = 1'b0;
      case (seg)
         GLYPH_0: nibble = 4'h0;
         GLYPH_1: nibble = 4'h1;
         GLYPH_2: nibble = 4'h2;
         GLYPH_3: nibble = 4'h3;
         GLYPH_4: nibble = 4'h4;
         GLYPH_5: nibble = 4'h5;
         GLYPH_6: nibble = 4'h6;
         GLYPH_7: nibble = 4'h7;
         GLYPH_8: nibble = 4'h8;
         GLYPH_9: nibble = 4'h9;
         GLYPH_A: nibble = 4'hA;
         GLYPH_B: nibble = 4'hB;
         GLYPH_C: nibble = 4'hC;
         GLYPH_D: nibble = 4'hD;
         GLYPH_E: nibble = 4'hE;
         GLYPH_F: nibble = 4'hF;
         default: err    = 1'b1;
      endcase
   end

endmodule

// File: rtl/sevenseg_capture.sv
// rtl/sevenseg_capture.sv - settle, decode and assemble scanned display frames
module sevenseg_capture
   import sevenseg_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic          system1000,
   input  logic          system1000_rst,
   sevenseg_capture_if.slave bus
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [SYNC_STAGES-1:0][3:0] a_sync;
   logic [SYNC_STAGES-1:0][7:0] s_sync;
   logic [3:0]  a_s;
   logic [7:0]  s_s;
   logic [11:0] prev_bus;
   logic        stable;
   logic [SW-1:0] settle_cnt;
   logic [TW-1:0] to_cnt;
   logic [TW-1:0] to_cnt_next;
   logic        one_cold;
   logic [1:0]  idx;
   logic        capture;
   logic [3:0]  dec_nib;
   logic        dec_err;
   logic [3:0]  seen;
   logic [3:0]  seen_next;
   frame_t      work;
   frame_t      work_next;
   frame_t      out_frame;
   logic        frame_q;
   logic        stale_q;

   // Synchronizer chain; resets to a blank bus
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         a_sync <= '1;
         s_sync <= '1;
      end else begin
         a_sync[0] <= bus.anode_i;
         s_sync[0] <= bus.seg_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            a_sync[i] <= a_sync[i-1];
            s_sync[i] <= s_sync[i-1];
         end
      end
   end

   assign a_s    = a_sync[SYNC_STAGES-1];
   assign s_s    = s_sync[SYNC_STAGES-1];
   assign stable = ({a_s, s_s} == prev_bus);

   // Digit select decode; only a single low anode bit names a digit
   always_comb begin
      one_cold = 1'b1;
      idx      = 2'd0;
      case (a_s)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: one_cold = 1'b0;
      endcase
   end

   // Capture only on the cycle the settle count reaches its limit
   assign capture = stable && (settle_cnt == SW'(SETTLE_CYCLES - 1)) && one_cold;

   sevenseg_glyph_decode u_decode (
      .seg    (s_s[SEG_G:SEG_A]),
      .nibble (dec_nib),
      .err    (dec_err)
   );

   // Settle counter: restart on any bus change, saturate once settled
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         prev_bus   <= '1;
         settle_cnt <= '0;
      end else begin
         prev_bus <= {a_s, s_s};
         if (!stable)
            settle_cnt <= '0;
         else if (settle_cnt != SW'(SETTLE_CYCLES))
            settle_cnt <= settle_cnt + 1'b1;
      end
   end

   // Working slots and seen mask including the current capture
   always_comb begin
      work_next = work;
      seen_next = seen;
      if (capture) begin
         work_next.nib[idx] = dec_nib;
         work_next.dp[idx]  = ~s_s[SEG_DP];
         work_next.err[idx] = dec_err;
         seen_next[idx]     = 1'b1;
      end
   end

   // Inactivity counter, saturating at the timeout
   always_comb begin
      to_cnt_next = to_cnt;
      if (capture)
         to_cnt_next = '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES))
         to_cnt_next = to_cnt + 1'b1;
   end

   // Frame assembly, stale flag and timeout discard of partial frames
   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         work      <= '0;
         seen      <= '0;
         out_frame <= '0;
         frame_q   <= 1'b0;
         to_cnt    <= '0;
         stale_q   <= 1'b1;
      end else begin
         work    <= work_next;
         to_cnt  <= to_cnt_next;
         frame_q <= 1'b0;
         if (capture)
            stale_q <= 1'b0;
         else if (to_cnt_next == TW'(TIMEOUT_CYCLES))
            stale_q <= 1'b1;
         if (capture && seen_next == 4'b1111) begin
            out_frame <= work_next;
            frame_q   <= 1'b1;
            seen      <= '0;
         end else if (!capture && to_cnt_next == TW'(TIMEOUT_CYCLES)) begin
            seen <= '0;
         end else begin
            seen <= seen_next;
         end
      end
   end

   assign bus.digits_o    = out_frame.nib;
   assign bus.dp_o        = out_frame.dp;
   assign bus.glyph_err_o = out_frame.err;
   assign bus.frame_o     = frame_q;
   assign bus.stale_o     = stale_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// tb/tb_sevenseg_capture.sv - directed self-checking bench for sevenseg_capture
module tb_sevenseg_capture;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   frames = 0;
   int   caps   = 0;

   always #5 clk = ~clk;

   sevenseg_capture_if bus ();

   sevenseg_capture #(
      .SYNC_STAGES    (2),
      .SETTLE_CYCLES  (16),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .bus            (bus)
   );

   // Event counters sampled away from the active edge
   always @(negedge clk) begin
      if (bus.frame_o === 1'b1) frames++;
      if (dut.capture === 1'b1) caps++;
   end

   task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
      bus.anode_i = a;
      bus.seg_i   = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic scan(input int d, input logic [7:0] s);
      logic [3:0] a;
      a = ~(4'b0001 << d);
      hold(a, s, 40);
      hold(4'hF, 8'hFF, 2);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      hold(4'hF, 8'hFF, 3);
      checks++; if (bus.digits_o !== 16'h0000) begin errors++; $display("FAIL reset_digits: got %h want %h", bus.digits_o, 16'h0000); end
      checks++; if (bus.dp_o !== 4'h0) begin errors++; $display("FAIL reset_dp: got %b want %b", bus.dp_o, 4'h0); end
      checks++; if (bus.glyph_err_o !== 4'h0) begin errors++; $display("FAIL reset_err: got %b want %b", bus.glyph_err_o, 4'h0); end
      checks++; if (bus.frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", bus.frame_o); end
      checks++; if (bus.stale_o !== 1'b1) begin errors++; $display("FAIL reset_stale: got %b want 1", bus.stale_o); end
      rst = 1'b0;
      hold(4'hF, 8'hFF, 2);
   endtask

   task automatic test_basic_frame;
      int f0;
      f0 = frames;
      scan(3, 8'h8E); scan(2, 8'hC0); scan(1, 8'h88); scan(0, 8'hF9);
      checks++; if (frames - f0 !== 1) begin errors++; $display("FAIL basic_frames: got %0d want 1", frames - f0); end
      checks++; if (bus.digits_o !== 16'hF0A1) begin errors++; $display("FAIL basic_digits: got %h want %h", bus.digits_o, 16'hF0A1); end
      checks++; if (bus.dp_o !== 4'b0000) begin errors++; $display("FAIL basic_dp: got %b want 0000", bus.dp_o); end
      checks++; if (bus.glyph_err_o !== 4'b0000) begin errors++; $display("FAIL basic_err: got %b want 0000", bus.glyph_err_o); end
      checks++; if (bus.stale_o !== 1'b0) begin errors++; $display("FAIL basic_stale: got %b want 0", bus.stale_o); end
   endtask

   task automatic test_long_hold_dp;
      int c0, f0;
      c0 = caps; f0 = frames;
      hold(4'b1110, 8'h12, 200);
      hold(4'hF, 8'hFF, 2);
      checks++; if (caps - c0 !== 1) begin errors++; $display("FAIL hold_captures: got %0d want 1", caps - c0); end
      checks++; if (frames - f0 !== 0) begin errors++; $display("FAIL hold_frames: got %0d want 0", frames - f0); end
      scan(3, 8'h80); scan(2, 8'h80); scan(1, 8'h80);
      checks++; if (frames - f0 !== 1) begin errors++; $display("FAIL hold_frame_done: got %0d want 1", frames - f0); end
      checks++; if (bus.digits_o !== 16'h8885) begin errors++; $display("FAIL hold_digits: got %h want %h", bus.digits_o, 16'h8885); end
      checks++; if (bus.dp_o !== 4'b0001) begin errors++; $display("FAIL hold_dp: got %b want 0001", bus.dp_o); end
   endtask

   task automatic test_bad_glyph;
      scan(3, 8'hB0); scan(2, 8'hFF); scan(1, 8'hB0); scan(0, 8'hB0);
      checks++; if (bus.digits_o !== 16'h3033) begin errors++; $display("FAIL badglyph_digits: got %h want %h", bus.digits_o, 16'h3033); end
      checks++; if (bus.glyph_err_o !== 4'b0100) begin errors++; $display("FAIL badglyph_err: got %b want 0100", bus.glyph_err_o); end
      checks++; if (bus.dp_o !== 4'b0000) begin errors++; $display("FAIL badglyph_dp: got %b want 0000", bus.dp_o); end
   endtask

   task automatic test_unstable;
      int c0, f0;
      c0 = caps; f0 = frames;
      for (int k = 0; k < 8; k++) hold(4'b1101, (k % 2 == 1) ? 8'h80 : 8'hB0, 8);
      hold(4'b0011, 8'hB0, 50);
      hold(4'hF, 8'hFF, 2);
      checks++; if (caps - c0 !== 0) begin errors++; $display("FAIL unstable_captures: got %0d want 0", caps - c0); end
      checks++; if (frames - f0 !== 0) begin errors++; $display("FAIL unstable_frames: got %0d want 0", frames - f0); end
      checks++; if (bus.digits_o !== 16'h3033) begin errors++; $display("FAIL unstable_digits: got %h want %h", bus.digits_o, 16'h3033); end
   endtask

   task automatic test_timeout;
      int c0, f0;
      c0 = caps;
      scan(0, 8'h86); scan(1, 8'h86);
      checks++; if (caps - c0 !== 2) begin errors++; $display("FAIL timeout_captures: got %0d want 2", caps - c0); end
      hold(4'hF, 8'hFF, 1000);
      checks++; if (bus.stale_o !== 1'b1) begin errors++; $display("FAIL timeout_stale: got %b want 1", bus.stale_o); end
      checks++; if (bus.digits_o !== 16'h3033) begin errors++; $display("FAIL timeout_keep_digits: got %h want %h", bus.digits_o, 16'h3033); end
      f0 = frames;
      scan(3, 8'h92); scan(2, 8'h82); scan(1, 8'hF8); scan(0, 8'h90);
      checks++; if (frames - f0 !== 1) begin errors++; $display("FAIL timeout_frames: got %0d want 1", frames - f0); end
      checks++; if (bus.digits_o !== 16'h5679) begin errors++; $display("FAIL timeout_digits: got %h want %h", bus.digits_o, 16'h5679); end
      checks++; if (bus.stale_o !== 1'b0) begin errors++; $display("FAIL timeout_unstale: got %b want 0", bus.stale_o); end
   endtask

   task automatic test_reset_midframe;
      int f0;
      scan(3, 8'hC6); scan(2, 8'hA1); scan(1, 8'h86);
      rst = 1'b1;
      #1;
      checks++; if (bus.digits_o !== 16'h0000) begin errors++; $display("FAIL midrst_digits: got %h want %h", bus.digits_o, 16'h0000); end
      checks++; if (bus.dp_o !== 4'h0) begin errors++; $display("FAIL midrst_dp: got %b want 0000", bus.dp_o); end
      checks++; if (bus.glyph_err_o !== 4'h0) begin errors++; $display("FAIL midrst_err: got %b want 0000", bus.glyph_err_o); end
      checks++; if (bus.stale_o !== 1'b1) begin errors++; $display("FAIL midrst_stale: got %b want 1", bus.stale_o); end
      hold(4'hF, 8'hFF, 2);
      rst = 1'b0;
      hold(4'hF, 8'hFF, 2);
      f0 = frames;
      scan(0, 8'h83);
      checks++; if (frames - f0 !== 0) begin errors++; $display("FAIL midrst_no_early_frame: got %0d want 0", frames - f0); end
      scan(3, 8'hF9); scan(2, 8'hA4); scan(1, 8'h99);
      checks++; if (frames - f0 !== 1) begin errors++; $display("FAIL midrst_frames: got %0d want 1", frames - f0); end
      checks++; if (bus.digits_o !== 16'h124B) begin errors++; $display("FAIL midrst_digits_new: got %h want %h", bus.digits_o, 16'h124B); end
   endtask

   initial begin
      bus.anode_i = 4'hF;
      bus.seg_i   = 8'hFF;
      test_reset();
      test_basic_frame();
      test_long_hold_dp();
      test_bad_glyph();
      test_unstable();
      test_timeout();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
